// File: rtl/resp_chk_pkg.sv
// Shared types and helpers for the resp_checker response monitor.
package resp_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/resp_cov_tracker.sv
// Coverage bitmap: one bit per input vector, with clear and set-index.
module resp_cov_tracker
  import resp_chk_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   set_en,
  input  logic [IN_W-1:0]        set_idx,
  output logic [(1<<IN_W)-1:0]   cov_map,
  output logic                   full,
  output logic                   full_nxt
);

  localparam int NV = 1 << IN_W;

  logic [NV-1:0] cov_q;
  logic [NV-1:0] cov_d;
  logic [NV-1:0] hit;

  always_comb begin
    hit = '0;
    hit[set_idx] = 1'b1;
    cov_d = cov_q;
    if (clr) begin
      cov_d = '0;
    end else if (set_en) begin
      cov_d = cov_q | hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cov_q <= '0;
    end else begin
      cov_q <= cov_d;
    end
  end

  assign cov_map  = cov_q;
  assign full     = &cov_q;
  assign full_nxt = &(cov_q | hit);

endmodule

// File: rtl/resp_checker.sv
// Response monitor: compares DUT output with EXP_TT, tracks coverage.
// Optional idle timeout abort: define RESP_CHK_TIMEOUT_EN.
module resp_checker
  import resp_chk_pkg::*;
#(
  parameter int                    IN_W    = 2,
  parameter logic [(1<<IN_W)-1:0]  EXP_TT  = 4'b1000,
  parameter int                    CNT_W   = 8,
  parameter int                    TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sample_valid,
  input  logic [IN_W-1:0]        in_vec,
  input  logic                   q_obs,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W-1:0]       smp_cnt,
  output logic [IN_W-1:0]        first_err_vec,
  output logic                   first_err_vld,
  output logic [(1<<IN_W)-1:0]   cov_map
`ifdef RESP_CHK_TIMEOUT_EN
  ,
  output logic                   timeout
`endif
);

  localparam logic [31:0] CNT_MAX =
    32'((64'd1 << CNT_W) - 64'd1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [IN_W-1:0]   fe_vec_q, fe_vec_d;
  logic              fe_vld_q, fe_vld_d;
  logic              cov_clr, cov_set;
  logic              cov_full, cov_full_nxt;
  logic              mis;

`ifdef RESP_CHK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              tmo_q, tmo_d;
`endif

  // X/Z on q_obs must register as a mismatch.
  assign mis = (q_obs !== EXP_TT[in_vec]);

  resp_cov_tracker #(.IN_W(IN_W)) u_cov (
    .clk      (clk),
    .rst      (rst),
    .clr      (cov_clr),
    .set_en   (cov_set),
    .set_idx  (in_vec),
    .cov_map  (cov_map),
    .full     (cov_full),
    .full_nxt (cov_full_nxt)
  );

  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    smp_cnt_d = smp_cnt_q;
    fe_vec_d  = fe_vec_q;
    fe_vld_d  = fe_vld_q;
    cov_clr   = 1'b0;
    cov_set   = 1'b0;
`ifdef RESP_CHK_TIMEOUT_EN
    idle_d    = '0;
    tmo_d     = tmo_q;
`endif
    if (start) begin
      state_d   = ST_CHECK;
      err_cnt_d = '0;
      smp_cnt_d = '0;
      fe_vec_d  = '0;
      fe_vld_d  = 1'b0;
      cov_clr   = 1'b1;
`ifdef RESP_CHK_TIMEOUT_EN
      tmo_d     = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_CHECK: begin
          if (sample_valid) begin
            cov_set   = 1'b1;
            smp_cnt_d = CNT_W'(sat_inc(32'(smp_cnt_q), CNT_MAX));
            if (mis) begin
              err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), CNT_MAX));
              if (!fe_vld_q) begin
                fe_vec_d = in_vec;
                fe_vld_d = 1'b1;
              end
            end
            if (cov_full_nxt) state_d = ST_DONE;
          end
`ifdef RESP_CHK_TIMEOUT_EN
          else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d = ST_DONE;
            tmo_d   = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
`endif
        end
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      err_cnt_q <= '0;
      smp_cnt_q <= '0;
      fe_vec_q  <= '0;
      fe_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      fe_vec_q  <= fe_vec_d;
      fe_vld_q  <= fe_vld_d;
    end
  end

`ifdef RESP_CHK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`endif

  assign busy          = (state_q == ST_CHECK);
  assign done          = (state_q == ST_DONE);
  assign pass          = done && (err_cnt_q == '0) && cov_full;
  assign err_cnt       = err_cnt_q;
  assign smp_cnt       = smp_cnt_q;
  assign first_err_vec = fe_vec_q;
  assign first_err_vld = fe_vld_q;

endmodule

// File: tb/tb_resp_checker.sv
// Directed bench for resp_checker (default params: 2-input AND).
module tb_resp_checker;

  logic       clk = 1'b0;
  logic       rst, start, sample_valid, q_obs;
  logic [1:0] in_vec;
  logic       busy, done, pass, first_err_vld;
  logic [7:0] err_cnt, smp_cnt;
  logic [1:0] first_err_vec;
  logic [3:0] cov_map;
`ifdef RESP_CHK_TIMEOUT_EN
  logic       timeout;
`endif

  resp_checker dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .sample_valid  (sample_valid),
    .in_vec        (in_vec),
    .q_obs         (q_obs),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .smp_cnt       (smp_cnt),
    .first_err_vec (first_err_vec),
    .first_err_vld (first_err_vld),
    .cov_map       (cov_map)
`ifdef RESP_CHK_TIMEOUT_EN
    ,
    .timeout       (timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         smp;
    int         err;
    logic [3:0] cov;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         m_smp, m_err;
  logic [3:0] m_cov;
  logic       m_fv;
  logic [1:0] m_fvec;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_model();
    m_smp  = 0;
    m_err  = 0;
    m_cov  = '0;
    m_fv   = 1'b0;
    m_fvec = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    clr_model();
  endtask

  task automatic send(input logic [1:0] v, input logic q);
    exp_t e;
    logic eq;
    sample_valid = 1'b1;
    in_vec = v;
    q_obs  = q;
    eq = v[0] & v[1];
    if (m_smp < 255) m_smp++;
    m_cov[v] = 1'b1;
    if (q !== eq) begin
      if (m_err < 255) m_err++;
      if (!m_fv) begin
        m_fv   = 1'b1;
        m_fvec = v;
      end
    end
    e.smp = m_smp;
    e.err = m_err;
    e.cov = m_cov;
    sbq.push_back(e);
    tick();
    sample_valid = 1'b0;
    e = sbq.pop_front();
    chk("smp_cnt", 32'(smp_cnt), 32'(e.smp));
    chk("err_cnt", 32'(err_cnt), 32'(e.err));
    chk("cov_map", 32'(cov_map), 32'(e.cov));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sample_valid = 1'b0;
    in_vec = '0;
    q_obs = 1'b0;
    clr_model();
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_cov", 32'(cov_map), 0);
    rst = 1'b0;
    tick();

    // clean run
    do_start();
    chk("st_busy", 32'(busy), 1);
    send(2'b00, 1'b0);
    send(2'b01, 1'b0);
    send(2'b10, 1'b0);
    chk("pre_done", 32'(done), 0);
    send(2'b11, 1'b1);
    chk("ok_done", 32'(done), 1);
    chk("ok_busy", 32'(busy), 0);
    chk("ok_pass", 32'(pass), 1);
    sample_valid = 1'b1;
    in_vec = 2'b00;
    q_obs = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("done_ign", 32'(smp_cnt), 4);
    chk("done_hold", 32'(done), 1);

    // one bad vector
    do_start();
    chk("rs_smp", 32'(smp_cnt), 0);
    send(2'b00, 1'b0);
    send(2'b01, 1'b1);
    send(2'b10, 1'b0);
    send(2'b11, 1'b1);
    chk("bad_done", 32'(done), 1);
    chk("bad_pass", 32'(pass), 0);
    chk("fe_vec", 32'(first_err_vec), 32'(m_fvec));
    chk("fe_vld", 32'(first_err_vld), 32'(m_fv));

    // X on q_obs counts as mismatch; repeats keep coverage
    do_start();
    send(2'b11, 1'bx);
    chk("x_fevec", 32'(first_err_vec), 3);
    send(2'b00, 1'b0);
    send(2'b00, 1'b0);
    send(2'b01, 1'b0);
    send(2'b10, 1'b1);
    chk("x_fevec2", 32'(first_err_vec), 3);
    chk("x_pass", 32'(pass), 0);

    // incomplete coverage
    do_start();
    send(2'b00, 1'b0);
    send(2'b00, 1'b0);
    send(2'b01, 1'b0);
    send(2'b10, 1'b0);
    chk("inc_busy", 32'(busy), 1);
    send(2'b11, 1'b1);
    chk("inc_done", 32'(done), 1);
    chk("inc_pass", 32'(pass), 1);

    // counter saturation
    do_start();
    for (int i = 0; i < 260; i++) send(2'b00, 1'b1);
    chk("sat_smp", 32'(smp_cnt), 255);
    chk("sat_err", 32'(err_cnt), 255);
    chk("sat_busy", 32'(busy), 1);

    // start coincident with a sample in CHECK
    start = 1'b1;
    sample_valid = 1'b1;
    in_vec = 2'b10;
    q_obs = 1'b0;
    tick();
    start = 1'b0;
    sample_valid = 1'b0;
    clr_model();
    chk("rs_smp0", 32'(smp_cnt), 0);
    chk("rs_cov0", 32'(cov_map), 0);
    chk("rs_busy", 32'(busy), 1);

    // async reset mid-run
    send(2'b00, 1'b0);
    send(2'b01, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_smp", 32'(smp_cnt), 0);
    chk("mr_err", 32'(err_cnt), 0);
    chk("mr_cov", 32'(cov_map), 0);
    chk("mr_fvld", 32'(first_err_vld), 0);
    rst = 1'b0;
    sample_valid = 1'b1;
    in_vec = 2'b11;
    q_obs = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("idle_ign", 32'(smp_cnt), 0);
    chk("idle_busy", 32'(busy), 0);

    // idle behaviour
    do_start();
    send(2'b00, 1'b0);
    for (int i = 0; i < 63; i++) tick();
    chk("to_busy63", 32'(busy), 1);
    tick();
`ifdef RESP_CHK_TIMEOUT_EN
    chk("to_done", 32'(done), 1);
    chk("to_flag", 32'(timeout), 1);
    chk("to_pass", 32'(pass), 0);
    do_start();
    chk("to_clr", 32'(timeout), 0);
`else
    chk("nto_busy", 32'(busy), 1);
    chk("nto_done", 32'(done), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/resp_checker.md
Name: resp_checker

Overview:
- Synthesizable self-checking response monitor for small combinational DUTs. It is the observing end of the stimulus/response pair.
- Samples each applied input vector together with the DUT output and compares the output against a parameterised expected truth table.
- Tracks coverage of all 2^IN_W input vectors and counts mismatches.
- Reports pass/fail and the first failing vector; used in benches and on-board self-test.

Parameters:
- IN_W, 2, number of DUT inputs; legal 1..6.
- EXP_TT, 4'b1000, expected truth table, width 2^IN_W; bit i = expected Q for input vector i (default is a 2-input AND).
- CNT_W, 8, width of the sample and error counters.
- TIMEOUT, 64, idle cycles before abort; used only with RESP_CHK_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; arms a new check run.
- sample_valid  in  1  in_vec/q_obs are valid this cycle.
- in_vec  in  IN_W  input vector applied to the DUT.
- q_obs  in  1  observed DUT output.
- busy  out  1  high in state CHECK.
- done  out  1  high in state DONE.
- pass  out  1  valid when done=1; 1 = zero errors and full coverage.
- err_cnt  out  CNT_W  number of mismatching samples, saturating.
- smp_cnt  out  CNT_W  number of accepted samples, saturating.
- first_err_vec  out  IN_W  in_vec of the first mismatch.
- first_err_vld  out  1  first_err_vec holds valid data.
- cov_map  out  2^IN_W  bit i set once vector i has been sampled.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; cov_map=0. Reset mid-run aborts immediately with no report.
- States: IDLE, CHECK, DONE; 2-bit encoding from the package.
- IDLE:
  - start=1 → CHECK. On that edge, clear err_cnt, smp_cnt, first_err_*, cov_map.
  - sample_valid is ignored.
- CHECK, on each sample_valid=1:
  - smp_cnt+1.
  - cov_map[in_vec] <= 1.
  - If q_obs != EXP_TT[in_vec]: err_cnt+1; if first_err_vld=0, capture first_err_vec <= in_vec and set first_err_vld.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- CHECK → DONE on the edge where cov_map becomes all-ones, including the sample that completes it.
- DONE:
  - done=1; pass = (err_cnt==0) && &cov_map.
  - All results hold until the next start.
  - start in DONE → CHECK, with clearing as in IDLE.
  - sample_valid is ignored.
- start while in CHECK restarts the run: counters and map clear. A sample presented in the same cycle is discarded.
- Latency: a sample is reflected in the registered outputs one cycle after its sample_valid edge. done rises in the cycle after the final covering sample.
- Repeated vectors are legal: each is counted and checked, and coverage is unchanged.
- X/Z on q_obs counts as a mismatch: the comparison uses !==.

Optional Feature:
- Macro: RESP_CHK_TIMEOUT_EN.
- Defined:
  - Idle counter runs in CHECK, reset by each sample_valid or start.
  - After TIMEOUT consecutive cycles with no sample → DONE with pass=0.
  - Adds output port timeout (1); set on timeout, cleared on start or reset.
- Undefined: no counter and no timeout port; CHECK waits indefinitely.

Decomposition:
- Package resp_chk_pkg: state encodings (ST_IDLE=2'd0, ST_CHECK=2'd1, ST_DONE=2'd2) and the saturating-increment function.
- One sub-module, resp_cov_tracker: holds cov_map, with clear, set-index and all-covered outputs.
- The FSM, compare, counters and timeout stay in resp_checker.

Test Plan:
- Reset, then start, then vectors 00,01,10,11 with q=0,0,0,1 → done after 4th sample+1 cycle; pass=1, err_cnt=0, smp_cnt=4, cov_map=4'hF.
- Same sequence with q=1 on vector 01 → pass=0, err_cnt=1, first_err_vec=2'b01, first_err_vld=1.
- Vectors 00,00,01,10 (11 missing) → stays busy, smp_cnt=4, cov_map=4'h7. Add 11 → done, pass=1.
- Assert rst mid-run after 2 samples → all outputs 0 immediately; state IDLE. Samples then ignored until start.
- start pulse coincident with a sample in CHECK → smp_cnt=0 next cycle, cov_map=0.
- With RESP_CHK_TIMEOUT_EN and TIMEOUT=64: start, one sample, then 64 idle cycles → done=1, timeout=1, pass=0. Without the macro: busy remains 1.
